// File: rtl/rem_unit8_if.sv
// Start/done handshake bundle between the ALU controller and the remainder unit.
// The controller drives operands and start; the unit returns registered results and status.
interface rem_unit8_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] reminder;
    logic [WIDTH-1:0] quotient;
    logic             busy;
    logic             done;
    logic             div_zero;

    modport master (
        output start, A, B,
        input  reminder, quotient, busy, done, div_zero
    );

    modport slave (
        input  start, A, B,
        output reminder, quotient, busy, done, div_zero
    );
endinterface

// File: rtl/rem_unit8.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
// Results are held in output registers that only change on entry to DONE.
module rem_unit8 #(
    parameter int WIDTH = 8
) (
    input logic        clk,
    input logic        rst,
    rem_unit8_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    // Partial remainder stays below D, so only WIDTH bits are stored; the extra
    // carry bit lives in the trial value t_w.
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic             dz_q, dz_d;

    logic [WIDTH:0]   t_w;
    logic             ge_w;
    logic [WIDTH-1:0] r_step_w;
    logic [WIDTH-1:0] q_step_w;

    always_comb begin
        t_w      = {r_q, q_q[WIDTH-1]};
        ge_w     = t_w[WIDTH] | (t_w[WIDTH-1:0] >= d_q);
        // When ge_w holds the true difference is below D, so the low bits suffice.
        r_step_w = ge_w ? (t_w[WIDTH-1:0] - d_q) : t_w[WIDTH-1:0];
        q_step_w = {q_q[WIDTH-2:0], ge_w};
    end

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dz_d    = dz_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    q_d     = bus.A;
                    d_d     = bus.B;
                    r_d     = '0;
                    cnt_d   = '0;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (d_q == '0) begin
                    // Q still holds the untouched dividend on this first cycle.
                    rem_d   = q_q;
                    quo_d   = '1;
                    dz_d    = 1'b1;
                    state_d = S_DONE;
                end else begin
                    r_d   = r_step_w;
                    q_d   = q_step_w;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        rem_d   = r_step_w;
                        quo_d   = q_step_w;
                        dz_d    = 1'b0;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dz_q    <= dz_d;
        end
    end

    assign bus.reminder = rem_q;
    assign bus.quotient = quo_q;
    assign bus.div_zero = dz_q;
    assign bus.busy     = (state_q != S_IDLE);
    assign bus.done     = (state_q == S_DONE);
endmodule

// File: tb/tb_rem_unit8.sv
// Randomised and directed checks of rem_unit8 against a plain-arithmetic reference.
module tb_rem_unit8;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    rem_unit8_if bus ();

    rem_unit8 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ref_rem(input logic [7:0] a, input logic [7:0] b);
        return (b == 8'd0) ? a : 8'(a % b);
    endfunction

    function automatic logic [7:0] ref_quo(input logic [7:0] a, input logic [7:0] b);
        return (b == 8'd0) ? 8'hFF : 8'(a / b);
    endfunction

    // One start pulse, then checks latency, results and busy/done shape.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input string tag);
        int n;
        int exp_lat;
        exp_lat = (b == 8'd0) ? 1 : 8;
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = a;
        bus.B     = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.A     = 8'($urandom);
        bus.B     = 8'($urandom);
        n = 0;
        check({tag, "_busy_rise"}, 32'(bus.busy), 32'd1);
        while (!bus.done && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'(exp_lat));
        check({tag, "_rem"}, 32'(bus.reminder), 32'(ref_rem(a, b)));
        check({tag, "_quo"}, 32'(bus.quotient), 32'(ref_quo(a, b)));
        check({tag, "_dz"}, 32'(bus.div_zero), 32'(b == 8'd0));
        check({tag, "_busy_at_done"}, 32'(bus.busy), 32'd1);
        $display("op %s A=%0d B=%0d rem=%0d quo=%0d dz=%0d lat=%0d", tag, a, b,
                 bus.reminder, bus.quotient, bus.div_zero, n);
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
        check({tag, "_busy_fall"}, 32'(bus.busy), 32'd0);
        check({tag, "_rem_hold"}, 32'(bus.reminder), 32'(ref_rem(a, b)));
    endtask

    function automatic logic [7:0] rand_b();
        return ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
    endfunction

    initial begin
        int dones;
        int first;
        int n;
        int exp_gap;
        logic [7:0] ca, cb, rem_s, quo_s;

        // Reset with start held high.
        rst       = 1'b1;
        bus.start = 1'b1;
        bus.A     = 8'd200;
        bus.B     = 8'd7;
        @(negedge clk);
        @(negedge clk);
        check("rst_rem", 32'(bus.reminder), 32'd0);
        check("rst_quo", 32'(bus.quotient), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_dz", 32'(bus.div_zero), 32'd0);
        $display("op reset asserted with start high");
        bus.start = 1'b0;
        rst       = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_busy", 32'(bus.busy), 32'd0);
        check("idle_done", 32'(bus.done), 32'd0);

        run_op(8'd200, 8'd7, "basic");
        run_op(8'd255, 8'd1, "b_one");
        run_op(8'd5, 8'd9, "a_lt_b");
        run_op(8'd0, 8'd3, "a_zero");
        run_op(8'd255, 8'd255, "a_eq_b");
        run_op(8'd77, 8'd0, "div0");
        run_op(8'd10, 8'd3, "after_div0");

        // Start pulses during BUSY must be ignored.
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = 8'd100;
        bus.B     = 8'd9;
        @(negedge clk);
        dones = 0;
        first = -1;
        rem_s = '0;
        quo_s = '0;
        for (int e = 1; e <= 25; e++) begin
            if (e >= 3 && e <= 5) begin
                bus.start = 1'b1;
                bus.A     = (e == 4) ? 8'd50 : 8'($urandom);
                bus.B     = (e == 4) ? 8'd4 : 8'($urandom);
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            if (bus.done) begin
                dones++;
                if (first < 0) begin
                    first = e;
                    rem_s = bus.reminder;
                    quo_s = bus.quotient;
                end
            end
        end
        check("proto_dones", 32'(dones), 32'd1);
        check("proto_edge", 32'(first), 32'd8);
        check("proto_rem", 32'(rem_s), 32'd1);
        check("proto_quo", 32'(quo_s), 32'd11);
        $display("op protocol A=100 B=9 dones=%0d rem=%0d quo=%0d", dones, rem_s, quo_s);

        // Abort mid-operation; prior results are nonzero so the clear is visible.
        run_op(8'd9, 8'd0, "pre_abort");
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = 8'd123;
        bus.B     = 8'd45;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_rem", 32'(bus.reminder), 32'd0);
        check("abort_quo", 32'(bus.quotient), 32'd0);
        check("abort_dz", 32'(bus.div_zero), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        repeat (2) @(negedge clk);
        rst   = 1'b0;
        dones = 0;
        for (int e = 0; e < 15; e++) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        check("abort_no_done", 32'(dones), 32'd0);
        $display("op abort A=123 B=45 dones_after=%0d", dones);

        // Back-to-back random operations with start held high.
        @(negedge clk);
        ca        = 8'($urandom);
        cb        = rand_b();
        bus.A     = ca;
        bus.B     = cb;
        bus.start = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            n       = (i == 0) ? -1 : 0;
            exp_gap = ((i == 0) ? 0 : 2) + ((cb == 8'd0) ? 1 : 8);
            do begin
                @(negedge clk);
                n++;
            end while (!bus.done && n < 20);
            check("rnd_gap", 32'(n), 32'(exp_gap));
            check("rnd_rem", 32'(bus.reminder), 32'(ref_rem(ca, cb)));
            check("rnd_quo", 32'(bus.quotient), 32'(ref_quo(ca, cb)));
            check("rnd_dz", 32'(bus.div_zero), 32'(cb == 8'd0));
            if (cb != 8'd0)
                check("rnd_invariant", 32'(16'(bus.quotient) * 16'(cb) + 16'(bus.reminder)), 32'(ca));
            $display("op rnd%0d A=%0d B=%0d rem=%0d quo=%0d dz=%0d gap=%0d", i, ca, cb,
                     bus.reminder, bus.quotient, bus.div_zero, n);
            ca    = 8'($urandom);
            cb    = rand_b();
            bus.A = ca;
            bus.B = cb;
        end
        bus.start = 1'b0;
        repeat (12) @(negedge clk);
        check("final_idle", 32'(bus.busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
